sdhci_auto_cmd_seq: RTL and testbench

Command-issue sequencer between the register block and the CMD-line PHY. It arbitrates driver commands against host-generated auto commands: Auto CMD12 after data transfers, and optional Auto CMD23 before them. It applies the SDHCI ordering and error-suppression rules and maintains the Auto CMD Error Status bits. It is the parametrised successor of the single-slot Auto CMD12 path: driver commands are queued, Auto CMD23 is added, and the argument is configurable.

---
 rtl/sdhci_auto_cmd_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_sdhci_auto_cmd_seq.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdhci_auto_cmd_seq.sv
// sdhci_auto_cmd_seq: CMD-line issue sequencer. Queues driver commands and
// interleaves host-generated Auto CMD12 (after transfers) and Auto CMD23
// (before flagged commands), applying the SDHCI ordering and
// error-suppression rules and keeping the Auto CMD Error Status bits.
module sdhci_auto_cmd_seq #(
    parameter int unsigned DrvQueueDepth = 1,
    parameter bit          AutoCmd23En   = 1'b0,
    parameter logic [31:0] Acmd12Arg     = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        drv_valid_i,
    output logic        drv_ready_o,
    input  logic [5:0]  drv_idx_i,
    input  logic [31:0] drv_arg_i,
    input  logic [1:0]  drv_rsp_type_i,
    input  logic        drv_auto23_i,
    input  logic [15:0] blk_cnt_i,
    input  logic        auto12_req_i,
    output logic        phy_valid_o,
    input  logic        phy_ready_i,
    output logic [5:0]  phy_idx_o,
    output logic [31:0] phy_arg_o,
    output logic [1:0]  phy_rsp_type_o,
    input  logic        phy_done_i,
    input  logic [3:0]  phy_err_i,
    output logic        drv_done_o,
    output logic [3:0]  drv_err_o,
    output logic        drv_flush_o,
    output logic [7:0]  acmd_err_o,
    input  logic [7:0]  acmd_err_clr_i
);

    localparam int unsigned    PtrW    = (DrvQueueDepth > 1) ? $clog2(DrvQueueDepth) : 1;
    localparam logic [2:0]     Depth   = 3'(DrvQueueDepth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DrvQueueDepth - 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] AUTO_ISSUE = 3'd1;
    localparam logic [2:0] AUTO_WAIT  = 3'd2;
    localparam logic [2:0] DRV_ISSUE  = 3'd3;
    localparam logic [2:0] DRV_WAIT   = 3'd4;

    logic [2:0]      state;
    logic            auto_sel;     // 0: CMD12 in flight, 1: CMD23 in flight
    logic            auto12_pend;
    logic            cmd23_done;   // CMD23 already completed for the queue head
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [2:0]      count;
    logic [40:0]     q_mem [1<<PtrW];
    logic [40:0]     head;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            flush;
    logic            pend_clr;
    logic [7:0]      acmd_set;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign head  = q_mem[rd_ptr];
    assign empty = (count == 3'd0);
    assign full  = (count == Depth);
    assign pop   = (state == DRV_WAIT) && phy_done_i;
    assign flush = (state == AUTO_WAIT) && phy_done_i && (phy_err_i != 4'h0) && !empty;
    // A full queue still accepts a push in the cycle its head retires.
    assign drv_ready_o = (!full || pop) && !rst_i;
    assign push        = drv_valid_i && drv_ready_o;

    // Queue storage: entry written on every accepted push.
    // NOTE: storage has no reset; count gates every read, so stale entries are never used.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_mem[wr_ptr] <= {drv_auto23_i, drv_rsp_type_i, drv_idx_i, drv_arg_i};
        end
    end

    // Queue pointers and occupancy; a flush keeps only a same-cycle push.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
                count  <= {2'b00, push};
            end else begin
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                count <= count + {2'b00, push} - {2'b00, pop};
            end
        end
    end

    // Completion side effects: which status bits to set, whether CMD12 is retired.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        acmd_set = 8'h00;
        pend_clr = 1'b0;
        if ((state == AUTO_WAIT) && phy_done_i) begin
            // A failed CMD12 is also retired; it is never retried.
            pend_clr = !auto_sel;
            if (phy_err_i != 4'h0) begin
                acmd_set[4:1] = phy_err_i;
                acmd_set[7]   = flush;
            end
        end
        if (pop && (phy_err_i != 4'h0) && auto12_pend) begin
            pend_clr    = 1'b1;
            acmd_set[0] = 1'b1;
        end
    end

    // Auto CMD12 request flag; repeated requests while pending collapse into one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            auto12_pend <= 1'b0;
        end else if (pend_clr) begin
            auto12_pend <= 1'b0;
        end else if (auto12_req_i) begin
            auto12_pend <= 1'b1;
        end
    end

    // CMD23 marker for the head; dropped when the head leaves the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i || pop || flush) begin
            cmd23_done <= 1'b0;
        end else if ((state == AUTO_WAIT) && phy_done_i && auto_sel && (phy_err_i == 4'h0)) begin
            cmd23_done <= 1'b1;
        end
    end

    // Sticky Auto CMD Error Status with write-1-to-clear; a set beats a clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acmd_err_o <= 8'h00;
        end else begin
            acmd_err_o <= (acmd_err_o & ~acmd_err_clr_i) | acmd_set;
        end
    end

    // Issue FSM: arbitrates CMD12 > CMD23 > driver head and drives the PHY handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            auto_sel       <= 1'b0;
            phy_valid_o    <= 1'b0;
            phy_idx_o      <= 6'd0;
            phy_arg_o      <= 32'h0;
            phy_rsp_type_o <= 2'b00;
            drv_done_o     <= 1'b0;
            drv_err_o      <= 4'h0;
            drv_flush_o    <= 1'b0;
        end else begin
            drv_done_o  <= 1'b0;
            drv_err_o   <= 4'h0;
            drv_flush_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (auto12_pend) begin
                        auto_sel       <= 1'b0;
                        phy_valid_o    <= 1'b1;
                        phy_idx_o      <= 6'd12;
                        phy_arg_o      <= Acmd12Arg;
                        phy_rsp_type_o <= 2'b11;
                        state          <= AUTO_ISSUE;
                    end else if (!empty) begin
                        phy_valid_o <= 1'b1;
                        if (AutoCmd23En && head[40] && !cmd23_done) begin
                            auto_sel       <= 1'b1;
                            phy_idx_o      <= 6'd23;
                            phy_arg_o      <= {16'h0, blk_cnt_i};
                            phy_rsp_type_o <= 2'b10;
                            state          <= AUTO_ISSUE;
                        end else begin
                            phy_idx_o      <= head[37:32];
                            phy_arg_o      <= head[31:0];
                            phy_rsp_type_o <= head[39:38];
                            state          <= DRV_ISSUE;
                        end
                    end
                end
                AUTO_ISSUE: begin
                    if (phy_ready_i) begin
                        phy_valid_o <= 1'b0;
                        state       <= AUTO_WAIT;
                    end
                end
                AUTO_WAIT: begin
                    if (phy_done_i) begin
                        drv_flush_o <= flush;
                        state       <= IDLE;
                    end
                end
                DRV_ISSUE: begin
                    if (phy_ready_i) begin
                        phy_valid_o <= 1'b0;
                        state       <= DRV_WAIT;
                    end
                end
                DRV_WAIT: begin
                    if (phy_done_i) begin
                        drv_done_o <= 1'b1;
                        drv_err_o  <= phy_err_i;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdhci_auto_cmd_seq.sv
// tb_sdhci_auto_cmd_seq: directed scenarios for the command-issue sequencer.
module tb_sdhci_auto_cmd_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        drv_valid_i;
    logic        drv_ready_o;
    logic [5:0]  drv_idx_i;
    logic [31:0] drv_arg_i;
    logic [1:0]  drv_rsp_type_i;
    logic        drv_auto23_i;
    logic [15:0] blk_cnt_i;
    logic        auto12_req_i;
    logic        phy_valid_o;
    logic        phy_ready_i;
    logic [5:0]  phy_idx_o;
    logic [31:0] phy_arg_o;
    logic [1:0]  phy_rsp_type_o;
    logic        phy_done_i;
    logic [3:0]  phy_err_i;
    logic        drv_done_o;
    logic [3:0]  drv_err_o;
    logic        drv_flush_o;
    logic [7:0]  acmd_err_o;
    logic [7:0]  acmd_err_clr_i;

    int checks = 0;
    int errors = 0;

    sdhci_auto_cmd_seq #(
        .DrvQueueDepth(4),
        .AutoCmd23En  (1'b1),
        .Acmd12Arg    (32'h0)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .drv_valid_i   (drv_valid_i),
        .drv_ready_o   (drv_ready_o),
        .drv_idx_i     (drv_idx_i),
        .drv_arg_i     (drv_arg_i),
        .drv_rsp_type_i(drv_rsp_type_i),
        .drv_auto23_i  (drv_auto23_i),
        .blk_cnt_i     (blk_cnt_i),
        .auto12_req_i  (auto12_req_i),
        .phy_valid_o   (phy_valid_o),
        .phy_ready_i   (phy_ready_i),
        .phy_idx_o     (phy_idx_o),
        .phy_arg_o     (phy_arg_o),
        .phy_rsp_type_o(phy_rsp_type_o),
        .phy_done_i    (phy_done_i),
        .phy_err_i     (phy_err_i),
        .drv_done_o    (drv_done_o),
        .drv_err_o     (drv_err_o),
        .drv_flush_o   (drv_flush_o),
        .acmd_err_o    (acmd_err_o),
        .acmd_err_clr_i(acmd_err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // PHY side: wait (bounded) for a launch, capture its fields, accept it.
    task automatic wait_issue(input int budget, output logic seen, output int cycles,
                              output logic [5:0] idx, output logic [31:0] arg,
                              output logic [1:0] typ);
        seen = 1'b0; cycles = 0; idx = '0; arg = '0; typ = '0;
        while (!phy_valid_o && cycles < budget) begin
            @(negedge clk_i);
            cycles++;
        end
        if (phy_valid_o) begin
            seen = 1'b1;
            idx  = phy_idx_o;
            arg  = phy_arg_o;
            typ  = phy_rsp_type_o;
            phy_ready_i = 1'b1;
            @(negedge clk_i);
            phy_ready_i = 1'b0;
        end
    endtask

    // PHY side: one-cycle completion, then sample the registered results.
    task automatic phy_respond(input logic [3:0] err, output logic done, output logic [3:0] derr,
                               output logic flush, output logic [7:0] acmd);
        phy_done_i = 1'b1;
        phy_err_i  = err;
        @(negedge clk_i);
        phy_done_i = 1'b0;
        phy_err_i  = 4'h0;
        done  = drv_done_o;
        derr  = drv_err_o;
        flush = drv_flush_o;
        acmd  = acmd_err_o;
    endtask

    task automatic drv_push(input logic [5:0] idx, input logic [31:0] arg,
                            input logic [1:0] typ, input logic a23);
        drv_valid_i = 1'b1; drv_idx_i = idx; drv_arg_i = arg;
        drv_rsp_type_i = typ; drv_auto23_i = a23;
        @(negedge clk_i);
        drv_valid_i = 1'b0; drv_auto23_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({phy_valid_o, drv_done_o, drv_flush_o, drv_ready_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000", {phy_valid_o, drv_done_o, drv_flush_o, drv_ready_o});
        end
        checks++;
        if ({drv_err_o, acmd_err_o} !== 12'h000) begin
            errors++;
            $display("FAIL reset_err: got %h required 000", {drv_err_o, acmd_err_o});
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (drv_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: got %b required 1", drv_ready_o);
        end
    endtask

    task automatic test_same_cycle();
        logic seen, done, flush; int cyc; logic [5:0] idx; logic [31:0] arg;
        logic [1:0] typ; logic [3:0] derr; logic [7:0] acmd;
        @(negedge clk_i);
        auto12_req_i = 1'b1;
        drv_valid_i = 1'b1; drv_idx_i = 6'd0; drv_arg_i = 32'h0; drv_rsp_type_i = 2'b10; drv_auto23_i = 1'b0;
        @(negedge clk_i);
        auto12_req_i = 1'b0; drv_valid_i = 1'b0;
        wait_issue(20, seen, cyc, idx, arg, typ);
        checks++;
        if ({seen, idx, arg, typ} !== {1'b1, 6'd12, 32'h0, 2'b11}) begin
            errors++;
            $display("FAIL same_cmd12_fields: got seen=%b idx=%0d arg=%h typ=%b required 1/12/0/11", seen, idx, arg, typ);
        end
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL same_cmd12_latency: got %0d required 1", cyc);
        end
        phy_respond(4'h0, done, derr, flush, acmd);
        checks++;
        if ({done, flush, acmd} !== {1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL same_cmd12_done: got done=%b flush=%b acmd=%h required 0/0/00", done, flush, acmd);
        end
        wait_issue(20, seen, cyc, idx, arg, typ);
        checks++;
        if ({seen, idx, arg, typ} !== {1'b1, 6'd0, 32'h0, 2'b10}) begin
            errors++;
            $display("FAIL same_cmd0_fields: got seen=%b idx=%0d arg=%h typ=%b required 1/0/0/10", seen, idx, arg, typ);
        end
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL back_to_back_latency: got %0d required 1", cyc);
        end
        phy_respond(4'h0, done, derr, flush, acmd);
        checks++;
        if ({done, derr, flush, acmd} !== {1'b1, 4'h0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL same_cmd0_done: got done=%b err=%h flush=%b acmd=%h required 1/0/0/00", done, derr, flush, acmd);
        end
    endtask

    task automatic test_drv_err_suppress();
        logic seen, done, flush; int cyc; int nv; logic [5:0] idx; logic [31:0] arg;
        logic [1:0] typ; logic [3:0] derr; logic [7:0] acmd;
        nv = 0;
        drv_push(6'd0, 32'h0, 2'b10, 1'b0);
        wait_issue(20, seen, cyc, idx, arg, typ);
        auto12_req_i = 1'b1;
        @(negedge clk_i);
        auto12_req_i = 1'b0;
        phy_respond(4'b1010, done, derr, flush, acmd);
        checks++;
        if ({seen, idx, done, derr, flush} !== {1'b1, 6'd0, 1'b1, 4'b1010, 1'b0}) begin
            errors++;
            $display("FAIL suppress_drv_done: got seen=%b idx=%0d done=%b err=%b flush=%b required 1/0/1/1010/0", seen, idx, done, derr, flush);
        end
        checks++;
        if (acmd !== 8'h01) begin
            errors++;
            $display("FAIL suppress_acmd: got %h required 01", acmd);
        end
        for (int c = 0; c < 80; c++) begin
            @(negedge clk_i);
            if (phy_valid_o) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL suppress_no_cmd12: got %0d launch cycles required 0", nv);
        end
        acmd_err_clr_i = 8'h01;
        @(negedge clk_i);
        acmd_err_clr_i = 8'h00;
        checks++;
        if (acmd_err_o !== 8'h00) begin
            errors++;
            $display("FAIL acmd_w1c: got %h required 00", acmd_err_o);
        end
    endtask

    task automatic test_cmd12_err_flush();
        logic seen, done, flush; int cyc; int nv; int nd; logic [5:0] idx; logic [31:0] arg;
        logic [1:0] typ; logic [3:0] derr; logic [7:0] acmd;
        nv = 0; nd = 0;
        auto12_req_i = 1'b1;
        drv_valid_i = 1'b1; drv_idx_i = 6'd17; drv_arg_i = 32'h0000_abcd; drv_rsp_type_i = 2'b10;
        @(negedge clk_i);
        auto12_req_i = 1'b0; drv_valid_i = 1'b0;
        wait_issue(20, seen, cyc, idx, arg, typ);
        checks++;
        if ({seen, idx} !== {1'b1, 6'd12}) begin
            errors++;
            $display("FAIL flush_cmd12_first: got seen=%b idx=%0d required 1/12", seen, idx);
        end
        phy_respond(4'b1010, done, derr, flush, acmd);
        checks++;
        if ({done, flush, acmd} !== {1'b0, 1'b1, 8'h94}) begin
            errors++;
            $display("FAIL flush_status: got done=%b flush=%b acmd=%h required 0/1/94", done, flush, acmd);
        end
        for (int c = 0; c < 80; c++) begin
            @(negedge clk_i);
            if (phy_valid_o) nv++;
            if (drv_done_o) nd++;
        end
        checks++;
        if ({nv, nd} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL flush_quiet: got launches=%0d dones=%0d required 0/0", nv, nd);
        end
        acmd_err_clr_i = 8'hff;
        @(negedge clk_i);
        acmd_err_clr_i = 8'h00;
    endtask

    task automatic test_absorb();
        logic seen, done, flush; int cyc; int nv; logic [5:0] idx; logic [31:0] arg;
        logic [1:0] typ; logic [3:0] derr; logic [7:0] acmd;
        nv = 0;
        auto12_req_i = 1'b1;
        repeat (2) @(negedge clk_i);
        auto12_req_i = 1'b0;
        wait_issue(20, seen, cyc, idx, arg, typ);
        phy_respond(4'h0, done, derr, flush, acmd);
        checks++;
        if ({seen, idx, acmd} !== {1'b1, 6'd12, 8'h00}) begin
            errors++;
            $display("FAIL absorb_cmd12: got seen=%b idx=%0d acmd=%h required 1/12/00", seen, idx, acmd);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (phy_valid_o) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL absorb_single: got %0d extra launch cycles required 0", nv);
        end
    endtask

    task automatic test_auto23();
        logic seen, done, flush; int cyc; int nv; logic [5:0] idx; logic [31:0] arg;
        logic [1:0] typ; logic [3:0] derr; logic [7:0] acmd;
        nv = 0;
        blk_cnt_i = 16'd5;
        drv_push(6'd25, 32'h0000_1234, 2'b10, 1'b1);
        wait_issue(20, seen, cyc, idx, arg, typ);
        checks++;
        if ({seen, idx, arg, typ} !== {1'b1, 6'd23, 32'h5, 2'b10}) begin
            errors++;
            $display("FAIL cmd23_fields: got seen=%b idx=%0d arg=%h typ=%b required 1/23/5/10", seen, idx, arg, typ);
        end
        phy_respond(4'h0, done, derr, flush, acmd);
        checks++;
        if ({done, acmd} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL cmd23_done: got done=%b acmd=%h required 0/00", done, acmd);
        end
        wait_issue(20, seen, cyc, idx, arg, typ);
        checks++;
        if ({seen, idx, arg, typ, cyc} !== {1'b1, 6'd25, 32'h1234, 2'b10, 32'd1}) begin
            errors++;
            $display("FAIL cmd25_after_23: got seen=%b idx=%0d arg=%h typ=%b cyc=%0d required 1/25/1234/10/1", seen, idx, arg, typ, cyc);
        end
        phy_respond(4'h0, done, derr, flush, acmd);
        checks++;
        if ({done, derr} !== {1'b1, 4'h0}) begin
            errors++;
            $display("FAIL cmd25_done: got done=%b err=%h required 1/0", done, derr);
        end
        drv_push(6'd25, 32'h0000_1234, 2'b10, 1'b1);
        wait_issue(20, seen, cyc, idx, arg, typ);
        phy_respond(4'b0001, done, derr, flush, acmd);
        checks++;
        if ({seen, idx, done, flush, acmd} !== {1'b1, 6'd23, 1'b0, 1'b1, 8'h82}) begin
            errors++;
            $display("FAIL cmd23_timeout: got seen=%b idx=%0d done=%b flush=%b acmd=%h required 1/23/0/1/82", seen, idx, done, flush, acmd);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (phy_valid_o) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL cmd23_timeout_no_cmd25: got %0d launch cycles required 0", nv);
        end
        acmd_err_clr_i = 8'hff;
        @(negedge clk_i);
        acmd_err_clr_i = 8'h00;
    endtask

    task automatic test_fifo_full();
        logic seen, done, flush; int cyc; logic [5:0] idx; logic [31:0] arg;
        logic [1:0] typ; logic [3:0] derr; logic [7:0] acmd;
        @(negedge clk_i);
        for (int k = 0; k < 5; k++) begin
            drv_valid_i = 1'b1; drv_idx_i = 6'(k + 1); drv_arg_i = 32'h100 + 32'(k);
            drv_rsp_type_i = 2'b10; drv_auto23_i = 1'b0;
            #1;
            checks++;
            if (drv_ready_o !== (k < 4)) begin
                errors++;
                $display("FAIL fifo_ready_%0d: got %b required %b", k, drv_ready_o, (k < 4));
            end
            @(negedge clk_i);
        end
        drv_valid_i = 1'b0;
        checks++;
        if ({phy_valid_o, phy_idx_o, phy_arg_o} !== {1'b1, 6'd1, 32'h100}) begin
            errors++;
            $display("FAIL fifo_hold_fields: got valid=%b idx=%0d arg=%h required 1/1/100", phy_valid_o, phy_idx_o, phy_arg_o);
        end
        for (int i = 0; i < 4; i++) begin
            wait_issue(10, seen, cyc, idx, arg, typ);
            phy_respond(4'h0, done, derr, flush, acmd);
            checks++;
            if ({seen, idx, arg, done} !== {1'b1, 6'(i + 1), 32'h100 + 32'(i), 1'b1}) begin
                errors++;
                $display("FAIL fifo_order_%0d: got seen=%b idx=%0d arg=%h done=%b required 1/%0d/%h/1", i, seen, idx, arg, done, i + 1, 32'h100 + 32'(i));
            end
        end
        drv_push(6'd5, 32'h104, 2'b10, 1'b0);
        wait_issue(10, seen, cyc, idx, arg, typ);
        phy_respond(4'h0, done, derr, flush, acmd);
        checks++;
        if ({seen, idx, done} !== {1'b1, 6'd5, 1'b1}) begin
            errors++;
            $display("FAIL fifo_fifth: got seen=%b idx=%0d done=%b required 1/5/1", seen, idx, done);
        end
    endtask

    task automatic test_reset_mid();
        logic seen, done, flush; int cyc; int nv; logic [5:0] idx; logic [31:0] arg;
        logic [1:0] typ; logic [3:0] derr; logic [7:0] acmd;
        nv = 0;
        drv_push(6'd8, 32'h8, 2'b10, 1'b0);
        wait_issue(20, seen, cyc, idx, arg, typ);
        drv_push(6'd9, 32'h9, 2'b10, 1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({phy_valid_o, drv_ready_o, drv_done_o, drv_flush_o, drv_err_o, acmd_err_o} !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%b ready=%b done=%b flush=%b err=%h acmd=%h required all 0",
                     phy_valid_o, drv_ready_o, drv_done_o, drv_flush_o, drv_err_o, acmd_err_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        phy_respond(4'hf, done, derr, flush, acmd);
        checks++;
        if ({done, derr, flush, acmd} !== {1'b0, 4'h0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midreset_late_done: got done=%b err=%h flush=%b acmd=%h required 0/0/0/00", done, derr, flush, acmd);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (phy_valid_o) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL midreset_queue_dropped: got %0d launch cycles required 0", nv);
        end
        drv_push(6'd10, 32'ha, 2'b01, 1'b0);
        wait_issue(20, seen, cyc, idx, arg, typ);
        phy_respond(4'h0, done, derr, flush, acmd);
        checks++;
        if ({seen, idx, arg, typ, done} !== {1'b1, 6'd10, 32'ha, 2'b01, 1'b1}) begin
            errors++;
            $display("FAIL midreset_recover: got seen=%b idx=%0d arg=%h typ=%b done=%b required 1/10/a/01/1", seen, idx, arg, typ, done);
        end
    endtask

    initial begin
        rst_i = 1'b1; drv_valid_i = 1'b0; drv_idx_i = '0; drv_arg_i = '0;
        drv_rsp_type_i = '0; drv_auto23_i = 1'b0; blk_cnt_i = '0; auto12_req_i = 1'b0;
        phy_ready_i = 1'b0; phy_done_i = 1'b0; phy_err_i = '0; acmd_err_clr_i = '0;
        test_reset();
        test_same_cycle();
        test_drv_err_suppress();
        test_cmd12_err_flush();
        test_absorb();
        test_auto23();
        test_fifo_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
